// File: rtl/mppt_po_ctrl.sv
// ---------------------------------------------------------------------------
// mppt_po_ctrl -- perturb-and-observe maximum power point tracker.
//
// Accepts one paired panel voltage/current sample per decision. It forms the
// power V*I and moves the PWM duty command one step up or down. The step
// direction follows the power trend. After every decision the controller
// waits SETTLE_CYCLES clocks, so the next sample reflects the new operating
// point.
//
// Ports:
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   en            tracking enable; low holds off sample acceptance
//   sample_valid  v_sample/i_sample valid
//   v_sample      panel voltage, unsigned, DATA_W bits
//   i_sample      panel current, unsigned, DATA_W bits
//   sample_ready  high only while waiting for a sample with en=1
//   duty          duty command to the PWM stage (clock counts per period)
//   duty_upd      one-cycle pulse after a decision that changed duty
//   dir_up        current perturbation direction (1 = increasing duty)
//   power         last computed power, full 2*DATA_W width
// ---------------------------------------------------------------------------
module mppt_po_ctrl #(
  parameter int DATA_W        = 12,
  parameter int DUTY_W        = 6,
  parameter int DUTY_INIT     = 20,
  parameter int DUTY_MIN      = 4,
  parameter int DUTY_MAX      = 36,
  parameter int STEP          = 1,
  parameter int SETTLE_CYCLES = 400
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  sample_valid,
  input  logic [DATA_W-1:0]     v_sample,
  input  logic [DATA_W-1:0]     i_sample,
  output logic                  sample_ready,
  output logic [DUTY_W-1:0]     duty,
  output logic                  duty_upd,
  output logic                  dir_up,
  output logic [2*DATA_W-1:0]   power
);

  localparam int PW_W  = 2 * DATA_W;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  // The step arithmetic uses one extra bit, so duty+STEP cannot wrap before
  // it is compared against the limits.
  localparam logic [DUTY_W:0] EXT_STEP   = (DUTY_W+1)'(STEP);
  localparam logic [DUTY_W:0] EXT_MAX    = (DUTY_W+1)'(DUTY_MAX);
  localparam logic [DUTY_W:0] EXT_DN_LIM = (DUTY_W+1)'(DUTY_MIN + STEP);

  typedef enum logic [1:0] {
    S_SETTLE,
    S_WAIT,
    S_MUL,
    S_DECIDE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   settle_cnt;
  logic [DATA_W-1:0]  v_reg;
  logic [DATA_W-1:0]  i_reg;
  logic [PW_W-1:0]    p_prev;
  logic               first;

  // Nothing is buffered: a sample exists for the controller only on a
  // handshake cycle.
  assign sample_ready = (state == S_WAIT) && en;

  logic [PW_W-1:0] prod;
  assign prod = PW_W'(v_reg) * PW_W'(i_reg);

  // Decision logic. It is evaluated only in DECIDE, where power already holds
  // the product of the sample just taken.
  logic              take_step;
  logic              step_up;
  logic [DUTY_W:0]   duty_ext;
  logic [DUTY_W:0]   up_sum;
  logic [DUTY_W:0]   dn_diff;
  logic [DUTY_W-1:0] duty_nxt;
  logic              dir_nxt;

  assign duty_ext = {1'b0, duty};
  assign up_sum   = duty_ext + EXT_STEP;
  assign dn_diff  = duty_ext - EXT_STEP;

  always_comb begin
    take_step = 1'b0;
    step_up   = dir_up;
    if (first) begin
      // No reference power yet: perturb in the reset direction.
      take_step = 1'b1;
    end else if (power > p_prev) begin
      take_step = 1'b1;
    end else if (power < p_prev) begin
      take_step = 1'b1;
      step_up   = ~dir_up;
    end

    duty_nxt = duty;
    dir_nxt  = dir_up;
    if (take_step) begin
      dir_nxt = step_up;
      if (step_up) begin
        if (up_sum > EXT_MAX) begin
          // At the ceiling, reverse so the next perturbation moves back in range.
          duty_nxt = DUTY_W'(DUTY_MAX);
          dir_nxt  = 1'b0;
        end else begin
          duty_nxt = up_sum[DUTY_W-1:0];
        end
      end else begin
        if (duty_ext < EXT_DN_LIM) begin
          duty_nxt = DUTY_W'(DUTY_MIN);
          dir_nxt  = 1'b1;
        end else begin
          duty_nxt = dn_diff[DUTY_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_SETTLE;
      settle_cnt <= '0;
      v_reg      <= '0;
      i_reg      <= '0;
      power      <= '0;
      p_prev     <= '0;
      first      <= 1'b1;
      duty       <= DUTY_W'(DUTY_INIT);
      dir_up     <= 1'b1;
      duty_upd   <= 1'b0;
    end else begin
      duty_upd <= 1'b0;
      case (state)
        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= S_WAIT;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (sample_valid && sample_ready) begin
            v_reg <= v_sample;
            i_reg <= i_sample;
            state <= S_MUL;
          end
        end
        S_MUL: begin
          power <= prod;
          state <= S_DECIDE;
        end
        S_DECIDE: begin
          duty     <= duty_nxt;
          dir_up   <= dir_nxt;
          // A step that clamps to the current value still reverses direction,
          // but it does not count as a duty update.
          duty_upd <= (duty_nxt != duty);
          p_prev   <= power;
          first    <= 1'b0;
          state    <= S_SETTLE;
        end
        default: state <= S_SETTLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mppt_po_ctrl.sv
`timescale 1ns/1ps
module tb_mppt_po_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic        sample_valid;
  logic [11:0] v_sample;
  logic [11:0] i_sample;
  logic        sample_ready;
  logic [5:0]  duty;
  logic        duty_upd;
  logic        dir_up;
  logic [23:0] power;

  int errors = 0;
  int checks = 0;

  mppt_po_ctrl dut (
    .clk(clk), .reset_n(reset_n), .en(en), .sample_valid(sample_valid),
    .v_sample(v_sample), .i_sample(i_sample), .sample_ready(sample_ready),
    .duty(duty), .duty_upd(duty_upd), .dir_up(dir_up), .power(power)
  );

  always #250 clk = ~clk;  // 2 MHz

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Counts negedges until sample_ready is seen high (bounded).
  task automatic wait_ready(output int n);
    n = 0;
    while (n < 1000) begin
      @(negedge clk);
      n++;
      if (sample_ready) break;
    end
    chk("ready_seen", {31'd0, sample_ready}, 32'd1);
  endtask

  task automatic do_sample(input string nm, input int v, input int i,
                           input int ed, input int edir, input int eupd);
    int n;
    wait_ready(n);
    sample_valid = 1'b1;
    v_sample = 12'(v);
    i_sample = 12'(i);
    @(negedge clk);
    sample_valid = 1'b0;
    chk({nm, ".rdy_mul"}, {31'd0, sample_ready}, 32'd0);
    @(negedge clk);
    chk({nm, ".power"}, {8'd0, power}, 32'(v * i));
    @(negedge clk);
    chk({nm, ".duty"}, {26'd0, duty}, 32'(ed));
    chk({nm, ".dir"}, {31'd0, dir_up}, 32'(edir));
    chk({nm, ".upd"}, {31'd0, duty_upd}, 32'(eupd));
    @(negedge clk);
    chk({nm, ".upd_off"}, {31'd0, duty_upd}, 32'd0);
  endtask

  initial begin
    int n;
    int seen;
    reset_n = 1'b0;
    en = 1'b1;
    sample_valid = 1'b0;
    v_sample = '0;
    i_sample = '0;
    repeat (3) @(negedge clk);
    chk("rst.duty", {26'd0, duty}, 32'd20);
    chk("rst.dir", {31'd0, dir_up}, 32'd1);
    chk("rst.upd", {31'd0, duty_upd}, 32'd0);
    chk("rst.rdy", {31'd0, sample_ready}, 32'd0);
    chk("rst.power", {8'd0, power}, 32'd0);
    reset_n = 1'b1;

    wait_ready(n);
    chk("settle_after_reset", 32'(n), 32'd400);
    chk("idle.duty", {26'd0, duty}, 32'd20);

    // First decision, then trend following.
    do_sample("s1", 100, 10, 21, 1, 1);
    wait_ready(n);
    chk("settle_after_decide", 32'(n), 32'd399);
    do_sample("s2", 100, 12, 22, 1, 1);
    do_sample("s3", 100, 11, 21, 0, 1);
    do_sample("s4_equal", 100, 11, 21, 0, 0);
    do_sample("s5_fall", 100, 10, 22, 1, 1);

    // Rising power drives duty to the ceiling.
    for (int k = 1; k <= 14; k++) do_sample("climb", 100, 10 + k, 22 + k, 1, 1);
    do_sample("clamp_hi", 100, 25, 36, 0, 0);
    do_sample("after_hi", 100, 26, 35, 0, 1);

    // Keep rising power: direction stays down until the floor.
    for (int k = 27; k <= 57; k++) do_sample("descend", 100, k, 35 - (k - 26), 0, 1);
    do_sample("clamp_lo", 100, 58, 4, 1, 0);
    do_sample("after_lo", 100, 59, 5, 1, 1);

    // Full-width product.
    do_sample("maxprod", 4095, 4095, 6, 1, 1);

    // sample_valid held through SETTLE, then WAIT with en=0: nothing taken.
    en = 1'b0;
    sample_valid = 1'b1;
    v_sample = 12'd300;
    i_sample = 12'd300;
    seen = 0;
    repeat (600) begin
      @(negedge clk);
      if (sample_ready) seen = 1;
    end
    chk("en0.no_ready", 32'(seen), 32'd0);
    chk("en0.duty", {26'd0, duty}, 32'd6);
    chk("en0.power", {8'd0, power}, 32'd16769025);
    sample_valid = 1'b0;
    en = 1'b1;
    #1;
    chk("en1.ready", {31'd0, sample_ready}, 32'd1);

    // Reset while the sample is in MUL: the sample is lost.
    wait_ready(n);
    sample_valid = 1'b1;
    v_sample = 12'd200;
    i_sample = 12'd200;
    @(negedge clk);
    sample_valid = 1'b0;
    chk("mulrst.rdy", {31'd0, sample_ready}, 32'd0);
    reset_n = 1'b0;
    #1;
    chk("mulrst.duty", {26'd0, duty}, 32'd20);
    chk("mulrst.power", {8'd0, power}, 32'd0);
    chk("mulrst.dir", {31'd0, dir_up}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    wait_ready(n);
    chk("mulrst.settle", 32'(n), 32'd400);
    chk("mulrst.power_after", {8'd0, power}, 32'd0);
    chk("mulrst.duty_after", {26'd0, duty}, 32'd20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mppt_po_ctrl.md
Name: mppt_po_ctrl

Overview:
- Perturb-and-observe MPPT controller that sits directly upstream of the PWM generator.
- Accepts paired panel voltage/current samples from the ADC front end over a valid/ready handshake and computes power V*I.
- Steps the duty command up or down according to the power trend and drives the PWM stage's duty input.
- Enforces a settle interval after every duty change, so each sample reflects the new operating point.

Parameters:
- DATA_W, 12: width of the unsigned voltage and current samples.
- DUTY_W, 6: width of the duty command, in PWM-period clock counts.
- DUTY_INIT, 20: duty after reset (50% of a 40-count period).
- DUTY_MIN, 4: lowest permitted duty.
- DUTY_MAX, 36: highest permitted duty.
- STEP, 1: perturbation size in counts.
- SETTLE_CYCLES, 400: clocks to wait after a duty update before accepting the next sample.

Ports:
- clk  in  1  system clock (2 MHz)
- reset_n  in  1  asynchronous active-low reset
- en  in  1  tracking enable; low blocks sample acceptance
- sample_valid  in  1  v_sample/i_sample valid
- v_sample  in  DATA_W  panel voltage, unsigned
- i_sample  in  DATA_W  panel current, unsigned
- sample_ready  out  1  controller can accept a sample
- duty  out  DUTY_W  duty command to the PWM stage
- duty_upd  out  1  one-cycle pulse when duty changes
- dir_up  out  1  current perturbation direction (1 = increasing)
- power  out  2*DATA_W  last computed power

Behaviour:
- Reset values (async, reset_n low):
  - duty=DUTY_INIT, dir_up=1, duty_upd=0, sample_ready=0, power=0.
  - p_prev=0, first flag=1, settle counter=0, state=SETTLE.
- States:
  - SETTLE: counter counts up. At SETTLE_CYCLES-1 the counter clears and the state goes to WAIT.
  - WAIT: sample_ready = en. A handshake (sample_valid && sample_ready) at edge k registers v and i and moves to MUL.
  - MUL: at edge k+1, power <= v*i, full 2*DATA_W width, no truncation. Next state is DECIDE.
  - DECIDE: at edge k+2, duty, dir_up, p_prev and first are updated, duty_upd is driven, and the state returns to SETTLE.
- sample_ready is combinational from state and en: high only in WAIT with en=1. sample_valid outside a handshake is ignored; nothing is buffered.
- DECIDE rules, evaluated in order:
  - first=1: no comparison. Apply a step in dir_up, p_prev <= power, first <= 0.
  - power > p_prev: keep dir_up, apply a step.
  - power < p_prev: invert dir_up, apply a step in the new direction.
  - power == p_prev: duty and dir_up unchanged, duty_upd stays 0, still go to SETTLE.
  - In every case p_prev <= power.
- Step and clamp:
  - Upward step: if duty+STEP > DUTY_MAX, then duty=DUTY_MAX and dir_up <= 0.
  - Downward step: if duty < DUTY_MIN+STEP, then duty=DUTY_MIN and dir_up <= 1.
  - Compute with one extra bit so there is no wrap-around.
- duty_upd:
  - High for exactly the one cycle after the DECIDE edge, and only if the duty value actually changed.
  - When duty is already at a limit and the step clamps to the same value, duty_upd=0 but dir_up still flips.
- Output stability: duty is stable except at the DECIDE edge. The downstream PWM stage latches it at its own period boundary.
- en:
  - en low in WAIT: sample_ready=0, no handshake, state remains WAIT.
  - en low in MUL/DECIDE/SETTLE: the operation in progress completes normally.
- Reset mid-operation: immediate return to reset values. Any in-flight sample is discarded.
- Throughput: at most one decision per SETTLE_CYCLES+3 clocks.

Test Plan:
- Reset, then hold reset_n=1 with sample_valid=0 -> duty=20, dir_up=1, sample_ready=0 for 400 clocks, then sample_ready=1.
- First sample v=100, i=10 -> power=1000 two edges after the handshake, duty=21, duty_upd pulses once, sample_ready drops for 400 clocks.
- Next sample v=100, i=12 (1200 > 1000) -> duty=22, dir_up=1. Next v=100, i=11 (1100 < 1200) -> dir_up=0, duty=21.
- Equal power (1100 again) -> duty=21, dir_up=0, duty_upd=0, state returns to SETTLE.
- Preload duty near 36 via rising-power samples -> duty stops at 36, dir_up becomes 0, the next rising sample gives duty=35. Mirror case clamps at 4.
- sample_valid held high during SETTLE and with en=0 -> no handshake, duty unchanged. Assert reset_n=0 during MUL -> duty=20, power=0, and the sample is dropped.
